// File: rtl/stack_ctrl.sv
// Stack controller for the calculator's single-port stack RAM.
// Serves PUSH/POP/PEEK/CLEAR requests one at a time and hides the RAM read latency.
module stack_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [DATA_W-1:0] req_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q
);

    localparam int WAIT_W = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);
    localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W + 1)'(DEPTH);
    localparam logic [WAIT_W-1:0] WAIT_END = WAIT_W'(RD_LAT);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        RESP
    } state_t;

    typedef enum logic [1:0] {
        OP_PUSH  = 2'b00,
        OP_POP   = 2'b01,
        OP_PEEK  = 2'b10,
        OP_CLEAR = 2'b11
    } op_t;

    state_t            state, state_n;
    op_t               op_r, op_n;
    logic [WAIT_W-1:0] wait_cnt, wait_n;
    logic [ADDR_W:0]   count_n;
    logic [ADDR_W:0]   count_m1;
    logic [ADDR_W-1:0] addr_n;
    logic [DATA_W-1:0] mdata_n;
    logic              wren_n;
    logic              rsp_valid_n;
    logic [DATA_W-1:0] rsp_data_n;
    logic              rsp_err_n;

    assign count_m1  = count - (ADDR_W + 1)'(1);
    assign empty     = (count == '0);
    assign full      = (count == DEPTH_C);
    assign req_ready = (state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            op_r      <= OP_PUSH;
            wait_cnt  <= '0;
            count     <= '0;
            mem_addr  <= '0;
            mem_data  <= '0;
            mem_wren  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_n;
            op_r      <= op_n;
            wait_cnt  <= wait_n;
            count     <= count_n;
            mem_addr  <= addr_n;
            mem_data  <= mdata_n;
            mem_wren  <= wren_n;
            rsp_valid <= rsp_valid_n;
            rsp_data  <= rsp_data_n;
            rsp_err   <= rsp_err_n;
        end
    end

    // RAM port and response fields are computed one cycle ahead so they leave the block registered.
    always_comb begin
        state_n     = state;
        op_n        = op_r;
        wait_n      = wait_cnt;
        count_n     = count;
        addr_n      = mem_addr;
        mdata_n     = mem_data;
        wren_n      = 1'b0;
        rsp_valid_n = 1'b0;
        rsp_data_n  = '0;
        rsp_err_n   = 1'b0;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    op_n = op_t'(req_op);
                    case (op_t'(req_op))
                        OP_PUSH: begin
                            if (full) begin
                                state_n     = RESP;
                                rsp_valid_n = 1'b1;
                                rsp_err_n   = 1'b1;
                            end else begin
                                state_n = WRITE;
                                addr_n  = count[ADDR_W-1:0];
                                mdata_n = req_data;
                                wren_n  = 1'b1;
                            end
                        end
                        OP_POP, OP_PEEK: begin
                            if (empty) begin
                                state_n     = RESP;
                                rsp_valid_n = 1'b1;
                                rsp_err_n   = 1'b1;
                            end else begin
                                state_n = READ;
                                addr_n  = count_m1[ADDR_W-1:0];
                                wait_n  = '0;
                            end
                        end
                        default: begin
                            state_n     = RESP;
                            rsp_valid_n = 1'b1;
                            count_n     = '0;
                        end
                    endcase
                end
            end
            WRITE: begin
                state_n     = RESP;
                rsp_valid_n = 1'b1;
                count_n     = count + (ADDR_W + 1)'(1);
            end
            READ: begin
                // The address has been stable since the first READ cycle; mem_q is valid RD_LAT cycles later.
                if (wait_cnt == WAIT_END) begin
                    state_n     = RESP;
                    rsp_valid_n = 1'b1;
                    rsp_data_n  = mem_q;
                    if (op_r == OP_POP) begin
                        count_n = count_m1;
                    end
                end else begin
                    wait_n = wait_cnt + WAIT_W'(1);
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
